// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial adder: FSM encoding, counter sizing,
// and the decoder-based full-adder cell.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width for n states, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Full adder built from a 3-to-8 minterm decoder; returns {carry, sum}.
    function automatic logic [1:0] fa_decode(input logic a, input logic b, input logic c);
        logic [7:0] m;
        m = 8'b1 << {a, b, c};
        return {m[3] | m[5] | m[6] | m[7], m[1] | m[2] | m[4] | m[7]};
    endfunction

endpackage

// File: rtl/serial_adder_n_digit.sv
// Purpose: DIGIT-bit combinational ripple of decoder-based full adders.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module digit_adder
    import adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic carry_w;

    always_comb begin
        sum     = '0;
        c_msb   = 1'b0;
        carry_w = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            // Carry entering the top bit survives the loop for overflow detection.
            c_msb = carry_w;
            {carry_w, sum[i]} = fa_decode(a[i], b[i], carry_w);
        end
        c_out = carry_w;
    end

endmodule

// File: rtl/serial_adder_n.sv
// Purpose: multi-cycle add/subtract of two WIDTH-bit operands, DIGIT bits per clock.
// Latency: WIDTH/DIGIT + 1 cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; no queueing, caller retries after done.
module serial_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_sh_q[DIGIT-1:0]),
        .b     (b_sh_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .sum   (dig_sum),
        .c_out (dig_cout),
        .c_msb (dig_cmsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is a + ~b + 1, so the operand is inverted at capture.
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sub}};
                    carry_d = sub | c_in;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                // Digits enter at the top so the LSB digit lands at bit 0 after N shifts.
                res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    c_out_d = dig_cout;
                    ovf_d   = dig_cout ^ dig_cmsb;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: five widths/digit sizes share one stimulus stream and are
// scored every cycle against an arithmetic model of the start/done protocol.
module tb_serial_adder_n;

    localparam int NI = 5;

    function automatic int wid_of(input int k);
        return (k == 0) ? 8 : 32;
    endfunction

    function automatic int dig_of(input int k);
        case (k)
            0, 1:    return 1;
            2:       return 2;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset, start, sub, c_in;
    logic [31:0] a_in, b_in;

    logic [NI-1:0] busy_o, done_o, cout_o, ovf_o;
    logic [31:0]   sum_o [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int W = wid_of(k);
        logic [W-1:0] s;
        serial_adder_n #(
            .WIDTH (W),
            .DIGIT (dig_of(k))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .sub      (sub),
            .a        (a_in[W-1:0]),
            .b        (b_in[W-1:0]),
            .c_in     (c_in),
            .busy     (busy_o[k]),
            .done     (done_o[k]),
            .sum      (s),
            .c_out    (cout_o[k]),
            .overflow (ovf_o[k])
        );
        assign sum_o[k] = 32'(s);
    end

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int op_c0  = 0;

    // Model state per instance: one pending result plus the held outputs.
    bit          pend  [NI];
    int          dn_c  [NI];
    logic [31:0] p_sum [NI];
    logic        p_co  [NI];
    logic        p_ov  [NI];
    logic [31:0] h_sum [NI];
    logic        h_co  [NI];
    logic        h_ov  [NI];
    int          bcnt  [NI];
    int          dcnt  [NI];
    int          dfirst[NI];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic void ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb,
                                   output logic [31:0] s, output logic co, output logic ov);
        longint m, ua, ub, cin, full, half, sa, sbv, r;
        m    = (longint'(1) << w) - 1;
        ua   = longint'(a) & m;
        ub   = longint'(sb ? ~b : b) & m;
        cin  = sb ? 1 : longint'(ci);
        full = ua + ub + cin;
        s    = 32'(full & m);
        co   = ((full >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sbv  = (ub >= half) ? ub - 2 * half : ub;
        r    = sa + sbv + cin;
        ov   = (r >= half) || (r < -half);
    endfunction

    // Score the current cycle, then apply this cycle's inputs to the model and advance.
    task automatic tick();
        for (int k = 0; k < NI; k++) begin
            bit dexp;
            dexp = 1'b0;
            if (pend[k] && cyc == dn_c[k]) begin
                h_sum[k] = p_sum[k];
                h_co[k]  = p_co[k];
                h_ov[k]  = p_ov[k];
                pend[k]  = 1'b0;
                dexp     = 1'b1;
            end
            chk($sformatf("busy[%0d]@%0d", k, cyc), 32'(busy_o[k]), 32'(pend[k]));
            chk($sformatf("done[%0d]@%0d", k, cyc), 32'(done_o[k]), 32'(dexp));
            chk($sformatf("sum[%0d]@%0d", k, cyc), sum_o[k], h_sum[k]);
            chk($sformatf("c_out[%0d]@%0d", k, cyc), 32'(cout_o[k]), 32'(h_co[k]));
            chk($sformatf("ovf[%0d]@%0d", k, cyc), 32'(ovf_o[k]), 32'(h_ov[k]));
            bcnt[k] += int'(busy_o[k]);
            if (done_o[k] === 1'b1) begin
                dcnt[k]++;
                if (dfirst[k] < 0) dfirst[k] = cyc - op_c0;
            end
        end
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                pend[k]  = 1'b0;
                h_sum[k] = '0;
                h_co[k]  = 1'b0;
                h_ov[k]  = 1'b0;
            end else if (start && !pend[k]) begin
                pend[k] = 1'b1;
                dn_c[k] = cyc + wid_of(k) / dig_of(k) + 1;
                ref_op(wid_of(k), a_in, b_in, c_in, sub, p_sum[k], p_co[k], p_ov[k]);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_stats();
        op_c0 = cyc;
        for (int k = 0; k < NI; k++) begin
            bcnt[k]   = 0;
            dcnt[k]   = 0;
            dfirst[k] = -1;
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic sb, input int ign_at);
        a_in  = a;
        b_in  = b;
        c_in  = ci;
        sub   = sb;
        start = 1'b1;
        clear_stats();
        tick();
        for (int c = 1; c <= 34; c++) begin
            start = 1'b0;
            if (c == ign_at) begin
                start = 1'b1;
                a_in  = $urandom;
                b_in  = $urandom;
                c_in  = 1'($urandom);
                sub   = 1'($urandom);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        c_in  = 1'b0;
        a_in  = '0;
        b_in  = '0;
        for (int k = 0; k < NI; k++) begin
            pend[k]  = 1'b0;
            dn_c[k]  = 0;
            h_sum[k] = '0;
            h_co[k]  = 1'b0;
            h_ov[k]  = 1'b0;
            p_sum[k] = '0;
            p_co[k]  = 1'b0;
            p_ov[k]  = 1'b0;
        end
        clear_stats();
        repeat (2) @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        op(32'h7F, 32'h01, 1'b0, 1'b0, 0);
        chk("t1_sum8", sum_o[0], 32'h80);
        chk("t1_cout8", 32'(cout_o[0]), 32'd0);
        chk("t1_ovf8", 32'(ovf_o[0]), 32'd1);
        chk("t1_done_cycle8", 32'(dfirst[0]), 32'd9);
        chk("t1_busy_len8", 32'(bcnt[0]), 32'd8);

        op(32'hFF, 32'h01, 1'b1, 1'b0, 0);
        chk("t2_sum8", sum_o[0], 32'h01);
        chk("t2_cout8", 32'(cout_o[0]), 32'd1);
        chk("t2_ovf8", 32'(ovf_o[0]), 32'd0);

        op(32'h05, 32'h07, 1'b0, 1'b1, 0);
        chk("t3_sum8", sum_o[0], 32'hFE);
        chk("t3_cout8", 32'(cout_o[0]), 32'd0);
        chk("t3_ovf8", 32'(ovf_o[0]), 32'd0);

        op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
        chk("t4_sum32d4", sum_o[3], 32'h0);
        chk("t4_cout32d4", 32'(cout_o[3]), 32'd1);
        chk("t4_busy_len32d4", 32'(bcnt[3]), 32'd8);
        chk("t4_done_cycle32d4", 32'(dfirst[3]), 32'd9);
        chk("t4_done_cycle32d1", 32'(dfirst[1]), 32'd33);

        op($urandom, $urandom, 1'($urandom), 1'b0, 3);
        for (int k = 0; k < NI; k++)
            chk($sformatf("ignored_start_single_done[%0d]", k), 32'(dcnt[k]), 32'd1);

        // Reset lands in cycle 4 of a run.
        a_in  = $urandom;
        b_in  = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("mid_reset_busy[%0d]", k), 32'(busy_o[k]), 32'd0);
            chk($sformatf("mid_reset_sum[%0d]", k), sum_o[k], 32'd0);
        end
        repeat (35) tick();
        op($urandom, $urandom, 1'($urandom), 1'($urandom), 0);

        // Reset and start together: reset must win.
        reset = 1'b1;
        start = 1'b1;
        a_in  = $urandom;
        tick();
        reset = 1'b0;
        start = 1'b0;
        repeat (35) tick();

        // Start held high with fresh operands every cycle.
        clear_stats();
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a_in = $urandom;
            b_in = $urandom;
            c_in = 1'($urandom);
            sub  = 1'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (35) tick();
        for (int k = 0; k < NI; k++) begin
            int per;
            per = wid_of(k) / dig_of(k) + 1;
            chk($sformatf("b2b_done_count[%0d]", k), 32'(dcnt[k]), 32'((300 + per - 1) / per));
        end

        for (int i = 0; i < 12; i++) begin
            op($urandom, $urandom, 1'($urandom), 1'($urandom), 0);
            repeat ($urandom_range(3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
